// File: rtl/c2c_pkg.sv
// Shared definitions for the C2C link responder.
//
// Contents:
//   - request opcode encodings (read/write)
//   - header and status word field positions
//   - AXI response codes and fixed AXI burst attributes
//   - responder FSM state enum
//   - pack/unpack helpers for the header and status word
//
// Header word : {15'b0, op[16], cnt[15:0]}       beats = cnt + 1
// Status word : {13'b0, resp[18:17], op[16], cnt[15:0]}
package c2c_pkg;

  localparam logic C2C_OP_READ  = 1'b0;
  localparam logic C2C_OP_WRITE = 1'b1;

  localparam int C2C_HDR_CNT_LSB   = 0;
  localparam int C2C_HDR_CNT_W     = 16;
  localparam int C2C_HDR_OP_BIT    = 16;
  localparam int C2C_STAT_RESP_LSB = 17;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  // Every beat is a full 32-bit word on an incrementing burst.
  localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [3:0] AXI_STRB_ALL   = 4'hF;

  typedef enum logic [3:0] {
    ST_HDR     = 4'd0,
    ST_ADDR_HI = 4'd1,
    ST_ADDR_LO = 4'd2,
    ST_AW      = 4'd3,
    ST_WDATA   = 4'd4,
    ST_BRESP   = 4'd5,
    ST_AR      = 4'd6,
    ST_PAD     = 4'd7,
    ST_RDATA   = 4'd8,
    ST_DRAIN   = 4'd9,
    ST_STATUS  = 4'd10
  } c2c_state_e;

  typedef struct packed {
    logic        op;
    logic [15:0] cnt;
  } c2c_hdr_t;

  typedef struct packed {
    logic [1:0] resp;
    c2c_hdr_t   hdr;
  } c2c_status_t;

  // Only the low 17 bits of a header carry information.
  function automatic c2c_hdr_t unpack_hdr(input logic [16:0] word);
    return c2c_hdr_t'(word);
  endfunction

  function automatic logic [31:0] pack_hdr(input c2c_hdr_t hdr);
    return {15'b0, hdr};
  endfunction

  function automatic logic [31:0] pack_status(input logic [1:0] resp, input c2c_hdr_t hdr);
    return {13'b0, resp, hdr};
  endfunction

  // Only the low 19 bits of a status word carry information.
  function automatic c2c_status_t unpack_status(input logic [18:0] word);
    return c2c_status_t'(word);
  endfunction

endpackage

// File: rtl/c2c_link_responder.sv
// c2c_link_responder -- far-chip end of the C2C link.
//
// Decodes 32-bit request frames from io_in, replays each request as a single
// AXI4 burst on io_m_axi, and returns read data plus a status word on io_out.
// Exactly one request is in flight; responses come back in request order.
//
// Ports:
//   clock, reset                 single clock, asynchronous active-low reset
//   io_in_*                      request frame stream (valid/ready/32-bit bits)
//   io_out_*                     response frame stream (valid/ready/32-bit bits)
//   io_m_axi_aw_* / w_* / b_*    AXI4 write channels (master side)
//   io_m_axi_ar_* / r_*          AXI4 read channels (master side)
//   io_stat_*                    optional 32-bit statistics counters
//
// Configuration macro:
//   C2C_RESPONDER_STATS_EN  adds io_stat_req_count, io_stat_err_count and
//                           io_stat_beat_count; absent when undefined.
//
// Parameters:
//   ADDR_WIDTH  AXI address width (32..64); higher address bits must be zero
//   AXI_ID      constant ID driven on AW and AR
//   MAX_BEATS   largest accepted burst length in beats
module c2c_link_responder
  import c2c_pkg::*;
#(
  parameter int         ADDR_WIDTH = 32,
  parameter logic [3:0] AXI_ID     = 4'h0,
  parameter int         MAX_BEATS  = 256
) (
  input  logic                  clock,
  input  logic                  reset,

  input  logic                  io_in_valid,
  output logic                  io_in_ready,
  input  logic [31:0]           io_in_bits,

  output logic                  io_out_valid,
  input  logic                  io_out_ready,
  output logic [31:0]           io_out_bits,

  output logic                  io_m_axi_aw_valid,
  input  logic                  io_m_axi_aw_ready,
  output logic [3:0]            io_m_axi_aw_bits_id,
  output logic [ADDR_WIDTH-1:0] io_m_axi_aw_bits_addr,
  output logic [7:0]            io_m_axi_aw_bits_len,
  output logic [2:0]            io_m_axi_aw_bits_size,
  output logic [1:0]            io_m_axi_aw_bits_burst,

  output logic                  io_m_axi_w_valid,
  input  logic                  io_m_axi_w_ready,
  output logic [31:0]           io_m_axi_w_bits_data,
  output logic [3:0]            io_m_axi_w_bits_strb,
  output logic                  io_m_axi_w_bits_last,

  input  logic                  io_m_axi_b_valid,
  output logic                  io_m_axi_b_ready,
  input  logic [3:0]            io_m_axi_b_bits_id,
  input  logic [1:0]            io_m_axi_b_bits_resp,

  output logic                  io_m_axi_ar_valid,
  input  logic                  io_m_axi_ar_ready,
  output logic [3:0]            io_m_axi_ar_bits_id,
  output logic [ADDR_WIDTH-1:0] io_m_axi_ar_bits_addr,
  output logic [7:0]            io_m_axi_ar_bits_len,
  output logic [2:0]            io_m_axi_ar_bits_size,
  output logic [1:0]            io_m_axi_ar_bits_burst,

  input  logic                  io_m_axi_r_valid,
  output logic                  io_m_axi_r_ready,
  input  logic [3:0]            io_m_axi_r_bits_id,
  input  logic [31:0]           io_m_axi_r_bits_data,
  input  logic [1:0]            io_m_axi_r_bits_resp,
  input  logic                  io_m_axi_r_bits_last
`ifdef C2C_RESPONDER_STATS_EN
  ,
  output logic [31:0]           io_stat_req_count,
  output logic [31:0]           io_stat_err_count,
  output logic [31:0]           io_stat_beat_count
`endif
);

  c2c_state_e            state;
  c2c_hdr_t              hdr;
  logic [31:0]           addr_hi;
  logic [ADDR_WIDTH-1:0] addr;
  logic [1:0]            resp;
  logic [15:0]           beat;

  logic        in_fire;
  logic        w_fire;
  logic        b_fire;
  logic        r_fire;
  logic        out_fire;
  logic [63:0] full_addr;
  logic        addr_bad;
  logic        cnt_bad;
  logic        unused_ids;

  // Transaction IDs are not used: only one request is ever outstanding.
  assign unused_ids = ^{io_m_axi_b_bits_id, io_m_axi_r_bits_id};

  assign in_fire  = io_in_valid & io_in_ready;
  assign w_fire   = io_m_axi_w_valid & io_m_axi_w_ready;
  assign b_fire   = io_m_axi_b_valid & io_m_axi_b_ready;
  assign r_fire   = io_m_axi_r_valid & io_m_axi_r_ready;
  assign out_fire = io_out_valid & io_out_ready;

  // Address check is evaluated while the low address word is on io_in, so the
  // routing decision (AW/AR vs DRAIN) is made in the same cycle it is accepted.
  assign full_addr = {addr_hi, io_in_bits};
  assign addr_bad  = (full_addr >> ADDR_WIDTH) != 64'd0;
  assign cnt_bad   = ({1'b0, hdr.cnt} + 17'd1) > 17'(MAX_BEATS);

  // ---------------------------------------------------------------------------
  // Request decode / transaction sequencing
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= ST_HDR;
      hdr     <= '0;
      addr_hi <= '0;
      addr    <= '0;
      resp    <= AXI_RESP_OKAY;
      beat    <= '0;
    end else begin
      case (state)
        ST_HDR: begin
          if (in_fire) begin
            hdr   <= unpack_hdr(io_in_bits[16:0]);
            resp  <= AXI_RESP_OKAY;
            state <= ST_ADDR_HI;
          end
        end
        ST_ADDR_HI: begin
          if (in_fire) begin
            addr_hi <= io_in_bits;
            state   <= ST_ADDR_LO;
          end
        end
        ST_ADDR_LO: begin
          if (in_fire) begin
            addr <= full_addr[ADDR_WIDTH-1:0];
            beat <= '0;
            if (addr_bad || cnt_bad) begin
              resp  <= AXI_RESP_DECERR;
              state <= ST_DRAIN;
            end else if (hdr.op == C2C_OP_WRITE) begin
              state <= ST_AW;
            end else begin
              state <= ST_AR;
            end
          end
        end
        ST_AW: begin
          if (io_m_axi_aw_ready) state <= ST_WDATA;
        end
        ST_WDATA: begin
          if (w_fire) begin
            beat <= beat + 16'd1;
            if (beat == hdr.cnt) state <= ST_BRESP;
          end
        end
        ST_BRESP: begin
          if (b_fire) begin
            resp  <= io_m_axi_b_bits_resp;
            state <= ST_STATUS;
          end
        end
        ST_AR: begin
          if (io_m_axi_ar_ready) state <= ST_PAD;
        end
        ST_PAD: begin
          if (in_fire) state <= ST_RDATA;
        end
        ST_RDATA: begin
          if (r_fire) begin
            // Report the worst response seen across the burst.
            if (io_m_axi_r_bits_resp > resp) resp <= io_m_axi_r_bits_resp;
            if (io_m_axi_r_bits_last) state <= ST_STATUS;
          end
        end
        ST_DRAIN: begin
          // A rejected write still carries cnt+1 data words; a read carries one pad.
          if (in_fire) begin
            beat <= beat + 16'd1;
            if (hdr.op == C2C_OP_READ || beat == hdr.cnt) state <= ST_STATUS;
          end
        end
        ST_STATUS: begin
          if (io_out_ready) state <= ST_HDR;
        end
        default: state <= ST_HDR;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Stream and AXI handshakes (combinational from state)
  // ---------------------------------------------------------------------------
  always_comb begin
    io_in_ready = 1'b0;
    case (state)
      ST_HDR, ST_ADDR_HI, ST_ADDR_LO, ST_PAD, ST_DRAIN: io_in_ready = 1'b1;
      ST_WDATA: io_in_ready = io_m_axi_w_ready;
      default:  io_in_ready = 1'b0;
    endcase
  end

  assign io_m_axi_aw_valid      = (state == ST_AW);
  assign io_m_axi_aw_bits_id    = AXI_ID;
  assign io_m_axi_aw_bits_addr  = addr;
  assign io_m_axi_aw_bits_len   = hdr.cnt[7:0];
  assign io_m_axi_aw_bits_size  = AXI_SIZE_4B;
  assign io_m_axi_aw_bits_burst = AXI_BURST_INCR;

  // Write data flows straight from io_in to W; data is gated to zero outside
  // WDATA so nothing stale appears on the bus.
  assign io_m_axi_w_valid     = (state == ST_WDATA) && io_in_valid;
  assign io_m_axi_w_bits_data = (state == ST_WDATA) ? io_in_bits : 32'd0;
  assign io_m_axi_w_bits_strb = AXI_STRB_ALL;
  assign io_m_axi_w_bits_last = (state == ST_WDATA) && (beat == hdr.cnt);

  assign io_m_axi_b_ready = (state == ST_BRESP);

  assign io_m_axi_ar_valid      = (state == ST_AR);
  assign io_m_axi_ar_bits_id    = AXI_ID;
  assign io_m_axi_ar_bits_addr  = addr;
  assign io_m_axi_ar_bits_len   = hdr.cnt[7:0];
  assign io_m_axi_ar_bits_size  = AXI_SIZE_4B;
  assign io_m_axi_ar_bits_burst = AXI_BURST_INCR;

  // Read data flows straight from R to io_out.
  assign io_m_axi_r_ready = (state == ST_RDATA) && io_out_ready;
  assign io_out_valid     = ((state == ST_RDATA) && io_m_axi_r_valid) || (state == ST_STATUS);

  always_comb begin
    io_out_bits = 32'd0;
    case (state)
      ST_RDATA:  io_out_bits = io_m_axi_r_bits_data;
      ST_STATUS: io_out_bits = pack_status(resp, hdr);
      default:   io_out_bits = 32'd0;
    endcase
  end

`ifdef C2C_RESPONDER_STATS_EN
  // ---------------------------------------------------------------------------
  // Optional statistics counters (free-running, wrap at 2^32)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      io_stat_req_count  <= '0;
      io_stat_err_count  <= '0;
      io_stat_beat_count <= '0;
    end else begin
      if (out_fire && state == ST_STATUS) begin
        io_stat_req_count <= io_stat_req_count + 32'd1;
        if (resp != AXI_RESP_OKAY) io_stat_err_count <= io_stat_err_count + 32'd1;
      end
      if (w_fire || r_fire) io_stat_beat_count <= io_stat_beat_count + 32'd1;
    end
  end
`else
  logic unused_out_fire;
  assign unused_out_fire = out_fire;
`endif

endmodule

// File: tb/tb_c2c_link_responder.sv
// Self-checking bench for c2c_link_responder: a reactive AXI slave plus a
// request-level reference model that predicts the response words and the AXI
// traffic for each request frame.
module tb_c2c_link_responder;

  localparam int         ADDR_WIDTH = 32;
  localparam logic [3:0] AXI_ID     = 4'h5;
  localparam int         MAX_BEATS  = 256;

  logic clock = 1'b0;
  logic reset = 1'b0;

  logic        io_in_valid = 1'b0;
  logic        io_in_ready;
  logic [31:0] io_in_bits  = 32'd0;
  logic        io_out_valid;
  logic        io_out_ready = 1'b0;
  logic [31:0] io_out_bits;

  logic                  aw_valid, aw_ready = 1'b0;
  logic [3:0]            aw_id;
  logic [ADDR_WIDTH-1:0] aw_addr;
  logic [7:0]            aw_len;
  logic [2:0]            aw_size;
  logic [1:0]            aw_burst;
  logic                  w_valid, w_ready = 1'b0;
  logic [31:0]           w_data;
  logic [3:0]            w_strb;
  logic                  w_last;
  logic                  b_valid = 1'b0, b_ready;
  logic [3:0]            b_id = 4'hA;
  logic [1:0]            b_resp = 2'b00;
  logic                  ar_valid, ar_ready = 1'b0;
  logic [3:0]            ar_id;
  logic [ADDR_WIDTH-1:0] ar_addr;
  logic [7:0]            ar_len;
  logic [2:0]            ar_size;
  logic [1:0]            ar_burst;
  logic                  r_valid = 1'b0, r_ready;
  logic [3:0]            r_id = 4'hB;
  logic [31:0]           r_data = 32'd0;
  logic [1:0]            r_resp = 2'b00;
  logic                  r_last = 1'b0;
`ifdef C2C_RESPONDER_STATS_EN
  logic [31:0] stat_req, stat_err, stat_beat;
`endif

  c2c_link_responder #(.ADDR_WIDTH(ADDR_WIDTH), .AXI_ID(AXI_ID), .MAX_BEATS(MAX_BEATS)) dut (
    .clock(clock), .reset(reset),
    .io_in_valid(io_in_valid), .io_in_ready(io_in_ready), .io_in_bits(io_in_bits),
    .io_out_valid(io_out_valid), .io_out_ready(io_out_ready), .io_out_bits(io_out_bits),
    .io_m_axi_aw_valid(aw_valid), .io_m_axi_aw_ready(aw_ready), .io_m_axi_aw_bits_id(aw_id),
    .io_m_axi_aw_bits_addr(aw_addr), .io_m_axi_aw_bits_len(aw_len), .io_m_axi_aw_bits_size(aw_size),
    .io_m_axi_aw_bits_burst(aw_burst),
    .io_m_axi_w_valid(w_valid), .io_m_axi_w_ready(w_ready), .io_m_axi_w_bits_data(w_data),
    .io_m_axi_w_bits_strb(w_strb), .io_m_axi_w_bits_last(w_last),
    .io_m_axi_b_valid(b_valid), .io_m_axi_b_ready(b_ready), .io_m_axi_b_bits_id(b_id),
    .io_m_axi_b_bits_resp(b_resp),
    .io_m_axi_ar_valid(ar_valid), .io_m_axi_ar_ready(ar_ready), .io_m_axi_ar_bits_id(ar_id),
    .io_m_axi_ar_bits_addr(ar_addr), .io_m_axi_ar_bits_len(ar_len), .io_m_axi_ar_bits_size(ar_size),
    .io_m_axi_ar_bits_burst(ar_burst),
    .io_m_axi_r_valid(r_valid), .io_m_axi_r_ready(r_ready), .io_m_axi_r_bits_id(r_id),
    .io_m_axi_r_bits_data(r_data), .io_m_axi_r_bits_resp(r_resp), .io_m_axi_r_bits_last(r_last)
`ifdef C2C_RESPONDER_STATS_EN
    , .io_stat_req_count(stat_req), .io_stat_err_count(stat_err), .io_stat_beat_count(stat_beat)
`endif
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Stimulus / slave configuration
  bit          rand_rdy = 1'b0;
  int          stall_out = 0;
  logic [31:0] in_words[$];
  logic [31:0] wdata_q[$];
  logic [31:0] cfg_rdata[$];
  logic [1:0]  cfg_rresp[$];
  logic [1:0]  cfg_bresp = 2'b00;

  // Observed traffic
  logic [ADDR_WIDTH-1:0] aw_addr_q[$], ar_addr_q[$];
  logic [7:0]            aw_len_q[$], ar_len_q[$];
  logic [8:0]            aw_misc_q[$], ar_misc_q[$];
  logic [31:0]           w_data_q[$];
  logic                  w_last_q[$];
  logic [3:0]            w_strb_q[$];
  logic [31:0]           out_q[$];
  logic [31:0]           exp_q[$];

  // Handshake events seen at the negedge, consumed by the slave after the edge
  bit w_last_flag = 0, b_fire_flag = 0, ar_fire_flag = 0, r_fire_flag = 0;
  int r_active = 0, r_idx = 0, r_len = 0, ar_len_latch = 0;

  // Monitor: handshakes are sampled on the falling edge, half a cycle before
  // the rising edge that completes them.
  initial forever begin
    @(negedge clock);
    if (reset) begin
      if (aw_valid && aw_ready) begin
        aw_addr_q.push_back(aw_addr); aw_len_q.push_back(aw_len);
        aw_misc_q.push_back({aw_id, aw_size, aw_burst});
      end
      if (w_valid && w_ready) begin
        w_data_q.push_back(w_data); w_last_q.push_back(w_last); w_strb_q.push_back(w_strb);
        if (w_last) w_last_flag = 1;
      end
      if (b_valid && b_ready) b_fire_flag = 1;
      if (ar_valid && ar_ready) begin
        ar_addr_q.push_back(ar_addr); ar_len_q.push_back(ar_len);
        ar_misc_q.push_back({ar_id, ar_size, ar_burst});
        ar_fire_flag = 1; ar_len_latch = int'(ar_len);
      end
      if (r_valid && r_ready) r_fire_flag = 1;
      if (io_out_valid && io_out_ready) out_q.push_back(io_out_bits);
      if (io_out_valid && !io_out_ready && stall_out > 0) stall_out--;
    end
  end

  // AXI slave and output sink, driven just after the rising edge.
  initial forever begin
    @(posedge clock); #1;
    if (!reset) begin
      b_valid = 0; r_valid = 0; r_active = 0;
      w_last_flag = 0; b_fire_flag = 0; ar_fire_flag = 0; r_fire_flag = 0;
      aw_ready = 0; w_ready = 0; ar_ready = 0; io_out_ready = 0;
    end else begin
      if (b_fire_flag) begin b_valid = 0; b_fire_flag = 0; end
      if (w_last_flag && !b_valid) begin b_valid = 1; b_resp = cfg_bresp; w_last_flag = 0; end
      if (r_fire_flag) begin
        r_fire_flag = 0; r_valid = 0; r_idx++;
        if (r_idx > r_len) r_active = 0;
      end
      if (ar_fire_flag) begin ar_fire_flag = 0; r_active = 1; r_idx = 0; r_len = ar_len_latch; end
      if (r_active != 0 && !r_valid && (!rand_rdy || $urandom_range(0, 3) != 0)) begin
        r_valid = 1; r_data = cfg_rdata[r_idx]; r_resp = cfg_rresp[r_idx]; r_last = (r_idx == r_len);
      end
      aw_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      w_ready  = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      ar_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      io_out_ready = (stall_out > 0) ? 1'b0 : (rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1);
    end
  end

  // Reference model: response words a request must produce, from the frame rules.
  task automatic model(input bit op, input int cnt, input logic [63:0] a);
    bit         err;
    logic [1:0] rs;
    err = ((a >> ADDR_WIDTH) != 64'd0) || (cnt + 1 > MAX_BEATS);
    exp_q.delete();
    rs = 2'b00;
    if (err) rs = 2'b11;
    else if (op) rs = cfg_bresp;
    else for (int i = 0; i <= cnt; i++) begin
      exp_q.push_back(cfg_rdata[i]);
      if (cfg_rresp[i] > rs) rs = cfg_rresp[i];
    end
    exp_q.push_back((32'(rs) << 17) | (32'(op) << 16) | 32'(cnt & 16'hFFFF));
  endtask

  task automatic drive_in();
    bit fired;
    int tmo;
    foreach (in_words[i]) begin
      if (rand_rdy && $urandom_range(0, 3) == 0) begin
        io_in_valid = 0; @(posedge clock); #1;
      end
      io_in_valid = 1; io_in_bits = in_words[i];
      fired = 0; tmo = 0;
      while (!fired && tmo < 2000) begin
        @(negedge clock); fired = io_in_ready;
        @(posedge clock); #1; tmo++;
      end
      if (!fired) begin
        checks++; errors++;
        $display("FAIL in_accept_timeout: word %0d not accepted, required accepted", i);
        break;
      end
    end
    io_in_valid = 0;
  endtask

  task automatic wait_out();
    int tmo = 0;
    while (out_q.size() < exp_q.size() && tmo < 4000) begin @(posedge clock); tmo++; end
    if (out_q.size() < exp_q.size()) begin
      checks++; errors++;
      $display("FAIL out_timeout: got %0d words required %0d", out_q.size(), exp_q.size());
    end
    repeat (3) @(posedge clock);
    #1;
  endtask

  // Issues one request frame and collects the resulting traffic.
  task automatic run_req(input bit op, input int cnt, input logic [63:0] a);
    aw_addr_q.delete(); aw_len_q.delete(); aw_misc_q.delete();
    ar_addr_q.delete(); ar_len_q.delete(); ar_misc_q.delete();
    w_data_q.delete(); w_last_q.delete(); w_strb_q.delete(); out_q.delete();
    in_words.delete();
    in_words.push_back((32'(op) << 16) | 32'(cnt & 16'hFFFF));
    in_words.push_back(a[63:32]);
    in_words.push_back(a[31:0]);
    if (op) for (int i = 0; i <= cnt; i++) in_words.push_back(wdata_q[i]);
    else in_words.push_back(32'h5A5A_0000);
    model(op, cnt, a);
    drive_in();
    wait_out();
  endtask

  task automatic test_reset();
    io_in_bits = 32'hFFFF_FFFF;
    repeat (3) @(posedge clock);
    #1;
    checks++;
    if ({aw_valid, w_valid, ar_valid, b_ready, r_ready, io_out_valid} !== 6'b0) begin
      errors++;
      $display("FAIL reset_valids: got %b required 000000",
               {aw_valid, w_valid, ar_valid, b_ready, r_ready, io_out_valid});
    end
    checks++;
    if ({aw_addr, ar_addr, io_out_bits, w_data} !== '0) begin
      errors++;
      $display("FAIL reset_data: aw %h ar %h out %h w %h required all 0", aw_addr, ar_addr, io_out_bits, w_data);
    end
    reset = 1; io_in_bits = 32'd0;
    repeat (2) @(posedge clock);
    #1;
  endtask

  task automatic test_write_single();
    rand_rdy = 0; cfg_bresp = 2'b00;
    wdata_q = '{32'h1111_1111};
    run_req(1'b1, 0, 64'h0);
    checks++;
    if (aw_addr_q.size() != 1 || ar_addr_q.size() != 0) begin
      errors++; $display("FAIL wr1_aw_count: aw %0d ar %0d required 1 0", aw_addr_q.size(), ar_addr_q.size());
    end else begin
      checks++;
      if ({aw_addr_q[0], aw_len_q[0], aw_misc_q[0]} !== {32'h0, 8'd0, AXI_ID, 3'b010, 2'b01}) begin
        errors++; $display("FAIL wr1_aw_fields: got %h %h %h required 0 0 %h", aw_addr_q[0], aw_len_q[0], aw_misc_q[0], {AXI_ID, 5'b01001});
      end
    end
    checks++;
    if (w_data_q.size() != 1 || w_data_q[0] !== 32'h1111_1111 || w_last_q[0] !== 1'b1 || w_strb_q[0] !== 4'hF) begin
      errors++; $display("FAIL wr1_w: got %0d beats, first %h required 1 beat 11111111 last strb F", w_data_q.size(), w_data_q.size() ? w_data_q[0] : 32'hx);
    end
    checks++;
    if (out_q.size() != exp_q.size()) begin errors++; $display("FAIL wr1_out_len: got %0d required %0d", out_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < out_q.size()) begin
      checks++;
      if (out_q[i] !== exp_q[i]) begin errors++; $display("FAIL wr1_out[%0d]: got %h required %h", i, out_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_read_single();
    rand_rdy = 0;
    cfg_rdata = '{32'hCAFE_F00D}; cfg_rresp = '{2'b00};
    run_req(1'b0, 0, 64'h24);
    checks++;
    if (ar_addr_q.size() != 1 || aw_addr_q.size() != 0) begin
      errors++; $display("FAIL rd1_ar_count: ar %0d aw %0d required 1 0", ar_addr_q.size(), aw_addr_q.size());
    end else begin
      checks++;
      if ({ar_addr_q[0], ar_len_q[0], ar_misc_q[0]} !== {32'h24, 8'd0, AXI_ID, 3'b010, 2'b01}) begin
        errors++; $display("FAIL rd1_ar_fields: got %h %h %h required 24 0 %h", ar_addr_q[0], ar_len_q[0], ar_misc_q[0], {AXI_ID, 5'b01001});
      end
    end
    checks++;
    if (out_q.size() != exp_q.size()) begin errors++; $display("FAIL rd1_out_len: got %0d required %0d", out_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < out_q.size()) begin
      checks++;
      if (out_q[i] !== exp_q[i]) begin errors++; $display("FAIL rd1_out[%0d]: got %h required %h", i, out_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_write_burst();
    rand_rdy = 1; cfg_bresp = 2'b00;
    wdata_q = '{32'hAABB_CCDD, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444};
    run_req(1'b1, 3, 64'h3000);
    checks++;
    if (aw_addr_q.size() != 1 || aw_addr_q[0] !== 32'h3000 || aw_len_q[0] !== 8'd3) begin
      errors++; $display("FAIL wr4_aw: got %0d aw, addr %h len %h required 1 aw 3000 3", aw_addr_q.size(),
                         aw_addr_q.size() ? aw_addr_q[0] : 32'hx, aw_len_q.size() ? aw_len_q[0] : 8'hx);
    end
    checks++;
    if (w_data_q.size() != 4) begin errors++; $display("FAIL wr4_w_count: got %0d required 4", w_data_q.size()); end
    foreach (w_data_q[i]) if (i < 4) begin
      checks++;
      if (w_data_q[i] !== wdata_q[i] || w_last_q[i] !== (i == 3)) begin
        errors++; $display("FAIL wr4_w[%0d]: got %h last %b required %h last %b", i, w_data_q[i], w_last_q[i], wdata_q[i], i == 3);
      end
    end
    checks++;
    if (out_q.size() != 1 || out_q[0] !== exp_q[0]) begin
      errors++; $display("FAIL wr4_status: got %0d words first %h required %h", out_q.size(), out_q.size() ? out_q[0] : 32'hx, exp_q[0]);
    end
  endtask

  task automatic test_decode_error();
    rand_rdy = 1;
    wdata_q = '{32'hDEAD_0001, 32'hDEAD_0002};
    run_req(1'b1, 1, 64'h0000_0001_0000_0040);
    checks++;
    if (aw_addr_q.size() + w_data_q.size() + ar_addr_q.size() != 0) begin
      errors++; $display("FAIL decerr_axi: got aw %0d w %0d ar %0d required none", aw_addr_q.size(), w_data_q.size(), ar_addr_q.size());
    end
    checks++;
    if (out_q.size() != 1 || out_q[0] !== exp_q[0]) begin
      errors++; $display("FAIL decerr_status: got %0d words first %h required %h", out_q.size(), out_q.size() ? out_q[0] : 32'hx, exp_q[0]);
    end
    // Oversized burst on a read: one pad drained, no data words, DECERR status.
    run_req(1'b0, 256, 64'h100);
    checks++;
    if (ar_addr_q.size() != 0 || out_q.size() != 1 || out_q[0] !== exp_q[0]) begin
      errors++; $display("FAIL decerr_len: ar %0d out %0d first %h required 0 1 %h", ar_addr_q.size(), out_q.size(), out_q.size() ? out_q[0] : 32'hx, exp_q[0]);
    end
  endtask

  task automatic test_read_max_burst();
    rand_rdy = 1;
    cfg_rdata.delete(); cfg_rresp.delete();
    for (int i = 0; i < 256; i++) begin cfg_rdata.push_back($urandom); cfg_rresp.push_back(2'b00); end
    run_req(1'b0, 255, 64'h8000);
    checks++;
    if (ar_len_q.size() != 1 || ar_len_q[0] !== 8'hFF) begin
      errors++; $display("FAIL rdmax_len: got %0d ar len %h required 1 ff", ar_len_q.size(), ar_len_q.size() ? ar_len_q[0] : 8'hx);
    end
    checks++;
    if (out_q.size() != exp_q.size()) begin errors++; $display("FAIL rdmax_out_len: got %0d required %0d", out_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < out_q.size() && out_q[i] !== exp_q[i]) begin
      errors++; $display("FAIL rdmax_out[%0d]: got %h required %h", i, out_q[i], exp_q[i]);
    end
  endtask

  task automatic test_read_stall();
    rand_rdy = 0;
    cfg_rdata = '{32'h1357_9BDF, 32'h2468_ACE0}; cfg_rresp = '{2'b00, 2'b10};
    stall_out = 3;
    run_req(1'b0, 1, 64'h40);
    checks++;
    if (out_q.size() != exp_q.size()) begin errors++; $display("FAIL rdstall_out_len: got %0d required %0d", out_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < out_q.size()) begin
      checks++;
      if (out_q[i] !== exp_q[i]) begin errors++; $display("FAIL rdstall_out[%0d]: got %h required %h", i, out_q[i], exp_q[i]); end
    end
    stall_out = 0;
  endtask

  task automatic test_reset_mid();
    rand_rdy = 0;
    out_q.delete();
    in_words = '{32'h0001_0003, 32'h0, 32'h100, 32'hAAAA_0001};
    drive_in();
    io_in_valid = 1; io_in_bits = 32'hBBBB_0002;
    #2;
    checks++;
    if (w_valid !== 1'b1) begin errors++; $display("FAIL rstmid_pre: w_valid got %b required 1", w_valid); end
    reset = 0;
    #1;
    checks++;
    if ({aw_valid, w_valid, ar_valid, b_ready, r_ready, io_out_valid} !== 6'b0) begin
      errors++; $display("FAIL rstmid_valids: got %b required 000000", {aw_valid, w_valid, ar_valid, b_ready, r_ready, io_out_valid});
    end
    io_in_valid = 0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1;
    @(posedge clock); #1;
    cfg_rdata = '{32'h0BAD_BEEF}; cfg_rresp = '{2'b00};
    run_req(1'b0, 0, 64'h200);
    checks++;
    if (ar_addr_q.size() != 1 || out_q.size() != 2 || out_q[0] !== exp_q[0] || out_q[1] !== exp_q[1]) begin
      errors++; $display("FAIL rstmid_read: ar %0d out %0d required 1 ar, words %h %h", ar_addr_q.size(), out_q.size(), exp_q[0], exp_q[1]);
    end
  endtask

  task automatic test_random();
    bit          op;
    int          cnt;
    logic [63:0] a;
    bit          err;
    rand_rdy = 1;
    for (int n = 0; n < 24; n++) begin
      op  = 1'($urandom_range(0, 1));
      cnt = $urandom_range(0, 5);
      if ($urandom_range(0, 11) == 0) cnt = 256 + $urandom_range(0, 2);
      a = {($urandom_range(0, 5) == 0) ? 32'($urandom_range(1, 255)) : 32'h0, 32'($urandom)};
      err = (a[63:32] != 0) || (cnt >= MAX_BEATS);
      wdata_q.delete(); cfg_rdata.delete(); cfg_rresp.delete();
      for (int i = 0; i <= cnt; i++) begin
        wdata_q.push_back($urandom); cfg_rdata.push_back($urandom); cfg_rresp.push_back(2'($urandom_range(0, 3)));
      end
      cfg_bresp = 2'($urandom_range(0, 3));
      run_req(op, cnt, a);
      checks++;
      if (out_q.size() != exp_q.size()) begin errors++; $display("FAIL rnd%0d_out_len: got %0d required %0d", n, out_q.size(), exp_q.size()); end
      foreach (exp_q[i]) if (i < out_q.size() && out_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL rnd%0d_out[%0d]: got %h required %h", n, i, out_q[i], exp_q[i]);
      end
      checks++;
      if (err) begin
        if (aw_addr_q.size() + w_data_q.size() + ar_addr_q.size() != 0) begin
          errors++; $display("FAIL rnd%0d_err_axi: aw %0d w %0d ar %0d required none", n, aw_addr_q.size(), w_data_q.size(), ar_addr_q.size());
        end
      end else if (op) begin
        if (aw_addr_q.size() != 1 || aw_addr_q[0] !== a[31:0] || aw_len_q[0] !== 8'(cnt) || w_data_q.size() != cnt + 1) begin
          errors++; $display("FAIL rnd%0d_wr: aw %0d w %0d required 1 aw at %h, %0d beats", n, aw_addr_q.size(), w_data_q.size(), a[31:0], cnt + 1);
        end else foreach (w_data_q[i]) if (w_data_q[i] !== wdata_q[i] || w_last_q[i] !== (i == cnt)) begin
          errors++; $display("FAIL rnd%0d_w[%0d]: got %h last %b required %h last %b", n, i, w_data_q[i], w_last_q[i], wdata_q[i], i == cnt);
        end
      end else begin
        if (ar_addr_q.size() != 1 || ar_addr_q[0] !== a[31:0] || ar_len_q[0] !== 8'(cnt) || aw_addr_q.size() != 0) begin
          errors++; $display("FAIL rnd%0d_rd: ar %0d required 1 ar at %h len %0d", n, ar_addr_q.size(), a[31:0], cnt);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_write_single();
    test_read_single();
    test_write_burst();
    test_decode_error();
    test_read_stall();
    test_read_max_burst();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
